// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared register-file types, default widths and FSM states
package core_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

  typedef enum logic {
    RF_INIT,
    RF_RUN
  } rf_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending bits with two bypass-aware busy lookups
module rf_scoreboard
  import core_pkg::*;
#(
  parameter int  NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          clr_valid,
  input  logic [AW-1:0] clr_addr,
  input  logic          set_valid,
  input  logic [AW-1:0] set_addr,
  input  logic [AW-1:0] look1,
  input  logic [AW-1:0] look2,
  output logic          busy1,
  output logic          busy2
);

  // Bit 0 is only ever written by reset, so x0 never reads as pending.
  logic [NREGS-1:0] pend;

  // Writeback clears, issue sets; the issue is applied last so the newer producer wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else if (run) begin
      for (int i = 1; i < NREGS; i++) begin
        if (set_valid && set_addr == AW'(i)) begin
          pend[i] <= 1'b1;
        end else if (clr_valid && clr_addr == AW'(i)) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // A writeback landing this cycle hides busy unless the same register is re-issued.
  function automatic logic lookup(input logic [AW-1:0] a);
    return pend[a] && !(clr_valid && clr_addr == a && !(set_valid && set_addr == a));
  endfunction

  assign busy1 = run && lookup(look1);
  assign busy2 = run && lookup(look2);

endmodule

// File: rtl/regfile_sb_bypass.sv
// rtl/regfile_sb_bypass.sv - 2R1W register file with init sweep, write bypass and scoreboard
module regfile_sb_bypass
  import core_pkg::*;
#(
  parameter int  XLEN  = XLEN_DEF,
  parameter int  NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            reg_write,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] write_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            init_done
);

  rf_state_t       state;
  rf_state_t       state_next;
  logic [AW-1:0]   cnt;
  logic [XLEN-1:0] mem [NREGS];
  logic            run;

  assign run       = (state == RF_RUN);
  assign init_done = run;

  // Init sweep ends once the last entry has been zeroed; RUN is left only by reset.
  always_comb begin
    state_next = state;
    if (state == RF_INIT && cnt == AW'(NREGS - 1)) begin
      state_next = RF_RUN;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RF_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Init counter starts at 1: entry 0 is never read from the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= AW'(1);
    end else if (state == RF_INIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Single array write port shared by the init sweep and writeback; reset edges leave it alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) begin
        mem[cnt] <= '0;
      end else if (reg_write && rd != '0) begin
        mem[rd] <= write_data;
      end
    end
  end

  // x0 and the init window read as zero; a same-cycle writeback is forwarded.
  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
    if (!run || a == '0) begin
      return '0;
    end
    if (reg_write && rd == a) begin
      return write_data;
    end
    return mem[a];
  endfunction

  assign read_data1 = read_port(rs1);
  assign read_data2 = read_port(rs2);

  rf_scoreboard #(
    .NREGS(NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .clr_valid(reg_write),
    .clr_addr (rd),
    .set_valid(issue_valid),
    .set_addr (issue_rd),
    .look1    (rs1),
    .look2    (rs2),
    .busy1    (rs1_busy),
    .busy2    (rs2_busy)
  );

endmodule
